cordic_rot: RTL and testbench

//  Pipelined CORDIC in rotation mode. Takes a phase in degrees (Q16.16, deg*2^16,
//  the same format cordic_vec produces) and returns cos/sin of that phase in Q16.16.

---
 rtl/cordic_rot.sv | 102 ++++++++++
 tb/tb_cordic_rot.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cordic_rot.sv
// Pipelined rotation-mode CORDIC: phase in degrees (Q16.16) to cos/sin (Q16.16).
// One quadrant-fold stage, STG micro-rotation stages and one output stage; 18 cycles.
module cordic_rot #(
   parameter logic signed [31:0] K       = 32'sh0000_9B74,
   parameter logic signed [31:0] ANG_90  = 32'sd5898240,
   parameter logic signed [31:0] ANG_180 = 32'sd11796480
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_in,
   input  logic signed [31:0] phase_in,
   output logic               valid_out,
   output logic signed [31:0] cos_out,
   output logic signed [31:0] sin_out,
   output logic               range_err
);

   // The atan table has exactly 16 entries, so the stage count is not tunable.
   localparam int STG = 16;

   localparam logic signed [31:0] ATAN [0:STG-1] = '{
      32'sd2949120, 32'sd1740992, 32'sd919872, 32'sd466944,
      32'sd234368,  32'sd117312,  32'sd58688,  32'sd29312,
      32'sd14656,   32'sd7360,    32'sd3648,   32'sd1856,
      32'sd896,     32'sd448,     32'sd256,    32'sd128
   };

   // Index 0 holds the fold-stage result; index i+1 holds micro-rotation i.
   logic signed [31:0] r_x   [0:STG];
   logic signed [31:0] r_y   [0:STG];
   logic signed [31:0] r_z   [0:STG];
   logic               r_neg [0:STG];
   logic               r_err [0:STG];
   logic               r_vld [0:STG];

   logic signed [31:0] w_z0;
   logic               w_neg;
   logic               w_err;

   // Fold into [-90, +90] and undo the half-turn with a sign flip at the output.
   always_comb begin
      w_z0  = phase_in;
      w_neg = 1'b0;
      if (phase_in > ANG_90) begin
         w_z0  = phase_in - ANG_180;
         w_neg = 1'b1;
      end else if (phase_in < -ANG_90) begin
         w_z0  = phase_in + ANG_180;
         w_neg = 1'b1;
      end
      w_err = (phase_in > ANG_180) || (phase_in < -ANG_180);
   end

   always_ff @(posedge clk) begin
      // NOTE: data registers are cleared too, not just the valid chain, so the outputs
      // read as zero right after reset rather than showing leftover samples.
      if (rst) begin
         for (int i = 0; i <= STG; i++) begin
            r_x[i]   <= '0;
            r_y[i]   <= '0;
            r_z[i]   <= '0;
            r_neg[i] <= 1'b0;
            r_err[i] <= 1'b0;
            r_vld[i] <= 1'b0;
         end
         valid_out <= 1'b0;
         cos_out   <= '0;
         sin_out   <= '0;
         range_err <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every stage read its predecessor's
         // previous-cycle value, which is what makes this a pipeline and not a chain.
         r_x[0]   <= K;
         r_y[0]   <= '0;
         r_z[0]   <= w_z0;
         r_neg[0] <= w_neg;
         r_err[0] <= w_err;
         r_vld[0] <= valid_in;

         for (int i = 0; i < STG; i++) begin
            if (r_z[i] >= 0) begin
               r_x[i+1] <= r_x[i] - (r_y[i] >>> i);
               r_y[i+1] <= r_y[i] + (r_x[i] >>> i);
               r_z[i+1] <= r_z[i] - ATAN[i];
            end else begin
               r_x[i+1] <= r_x[i] + (r_y[i] >>> i);
               r_y[i+1] <= r_y[i] - (r_x[i] >>> i);
               r_z[i+1] <= r_z[i] + ATAN[i];
            end
            r_neg[i+1] <= r_neg[i];
            r_err[i+1] <= r_err[i];
            r_vld[i+1] <= r_vld[i];
         end

         valid_out <= r_vld[STG];
         cos_out   <= r_neg[STG] ? -r_x[STG] : r_x[STG];
         sin_out   <= r_neg[STG] ? -r_y[STG] : r_y[STG];
         range_err <= r_err[STG] & r_vld[STG];
      end
   end

endmodule

// File: tb/tb_cordic_rot.sv
// Scoreboard bench for cordic_rot: expected cos/sin/range_err from a real-valued model,
// queued with their due cycle when driven and compared as valid_out appears.
module tb_cordic_rot;

   localparam int LAT     = 18;
   localparam int TOL     = 32;
   localparam int ANG_90  = 5898240;
   localparam int ANG_180 = 11796480;
   localparam int STEP    = 491520;   // 7.5 deg

   logic               clk = 1'b0;
   logic               rst;
   logic               valid_in;
   logic signed [31:0] phase_in;
   logic               valid_out;
   logic signed [31:0] cos_out;
   logic signed [31:0] sin_out;
   logic               range_err;

   cordic_rot dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .phase_in  (phase_in),
      .valid_out (valid_out),
      .cos_out   (cos_out),
      .sin_out   (sin_out),
      .range_err (range_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   due;
      int   phase;
      int   cos_e;
      int   sin_e;
      logic err;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   logic rst_q  = 1'b1;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input longint got, input longint exp,
                        input longint tol = 0);
      longint d;
      checks++;
      d = got - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d",
                  tag, got, exp, tol, cyc);
      end
   endtask

   function automatic exp_t model(input int ph, input int due);
      exp_t e;
      real  rad;
      rad     = $itor(ph) / 65536.0 * 3.14159265358979 / 180.0;
      e.due   = due;
      e.phase = ph;
      e.cos_e = $rtoi($floor(65536.0 * $cos(rad) + 0.5));
      e.sin_e = $rtoi($floor(65536.0 * $sin(rad) + 0.5));
      e.err   = (ph > ANG_180) || (ph < -ANG_180);
      return e;
   endfunction

   // Called just after a rising edge; the sample is taken on the next one.
   task automatic drive(input bit v, input int ph);
      valid_in = v;
      phase_in = ph;
      if (v) q.push_back(model(ph, cyc + LAT));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0);
   endtask

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   always @(negedge clk) begin : monitor
      bit   exp_v;
      exp_t e;
      if (rst_q) begin
         if (cyc > 0) begin
            check("rst_valid_out", valid_out, 0);
            check("rst_cos_out",   cos_out,   0);
            check("rst_sin_out",   sin_out,   0);
            check("rst_range_err", range_err, 0);
         end
         q.delete();
      end else begin
         exp_v = (q.size() > 0) && (q[0].due == cyc);
         check("valid_out", valid_out, exp_v);
         if (exp_v) begin
            e = q.pop_front();
            if (valid_out) begin
               check("range_err", range_err, e.err);
               if (!e.err) begin
                  check("cos_out", cos_out, e.cos_e, TOL);
                  check("sin_out", sin_out, e.sin_e, TOL);
               end
            end
         end
         while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      bit [9:0] pat;
      pat      = 10'b1011001110;
      rst      = 1'b1;
      valid_in = 1'b0;
      phase_in = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // Single zero-phase pulse, then the +/-90 boundaries (not folded).
      drive(1'b1, 0);
      idle(20);
      drive(1'b1, ANG_90);
      idle(3);
      drive(1'b1, -ANG_90);
      idle(20);

      // Fold path: 135 deg, -180 deg, +180 deg.
      drive(1'b1, 8847360);
      drive(1'b1, -ANG_180);
      drive(1'b1, ANG_180);
      idle(20);

      // Out-of-range samples followed by in-range ones.
      drive(1'b1, 13107200);
      drive(1'b1, 655360);
      drive(1'b1, -13107200);
      drive(1'b1, -ANG_90 - 1);
      idle(20);

      // 40-cycle gapped sweep in 7.5 deg steps.
      for (int k = 0; k < 40; k++)
         drive(pat[9 - (k % 10)], -ANG_180 + k * STEP);
      idle(20);

      // Fill the pipe, reset for one cycle, then resume.
      for (int k = 0; k < 10; k++) drive(1'b1, k * 1000000 - 4000000);
      rst = 1'b1;
      drive(1'b0, 0);
      rst = 1'b0;
      idle(4);
      for (int k = 0; k < 5; k++) drive(1'b1, 3000000 - k * 1500000);
      idle(25);

      check("drain_queue", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
